// File: rtl/ysyx_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package ysyx_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
    localparam logic [3:0]  MASK_WORD         = 4'b1111;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MAX_LATENCY = 15;
    localparam int unsigned LANES       = 4;
    localparam int unsigned BYTE_W      = 8;

    // True when addr lies in [base, base+span); the subtraction wraps so
    // addresses below base land far above span and are rejected.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] span);
        logic [31:0] off;
        off = addr - base;
        return (off < span);
    endfunction

endpackage

// File: rtl/ysyx_mem_array.sv
// DEPTH x 32 single-port word array, byte-lane write enables, synchronous read.
// A store access returns zero on the read port so callers get rdata=0 for free.
module ysyx_mem_array
    import ysyx_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          wen,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wmask,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Masked byte-lane write; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (en && wen) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (wmask[i]) begin
                    mem[idx][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
                end
            end
        end
    end

    // Registered read port; holds its value between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= wen ? 32'd0 : mem[idx];
        end
    end

endmodule

// File: rtl/ysyx_mem_responder.sv
// Data-memory responder: one word request at a time, fixed programmable latency,
// valid/ready request and response channels.
module ysyx_mem_responder
    import ysyx_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned      AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]      SPAN     = 32'(4 * DEPTH);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Latency must fit the 4-bit wait counter.
    generate
        if (LATENCY > MAX_LATENCY) begin : g_lat_check
            $error("ysyx_mem_responder: LATENCY must be 0..15");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wen_q;
    logic             err_q;
    logic [AW-1:0]    idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wmask_q;

    logic             in_range_c;
    logic [AW-1:0]    idx_c;
    logic             accept_c;
    logic             commit_c;
    logic             arr_wen_c;
    logic [AW-1:0]    arr_idx_c;
    logic [31:0]      arr_wdata_c;
    logic [3:0]       arr_wmask_c;

    // Range check and word index of the incoming request.
    always_comb begin
        in_range_c = in_window(req_addr, BASE_ADDR, SPAN);
        idx_c      = AW'((req_addr - BASE_ADDR) >> 2);
        accept_c   = (state == IDLE) && req_valid && req_ready;
    end

    // Array access on the edge that enters RESP; out-of-range requests become
    // a zero-mask store so nothing is written and the read port returns zero.
    always_comb begin
        commit_c    = 1'b0;
        arr_idx_c   = idx_q;
        arr_wen_c   = wen_q | err_q;
        arr_wmask_c = err_q ? 4'b0000 : wmask_q;
        arr_wdata_c = wdata_q;
        if ((state == WAIT) && (cnt == CNT_ONE)) begin
            commit_c = 1'b1;
        end else if (accept_c && (LATENCY == 0)) begin
            commit_c    = 1'b1;
            arr_idx_c   = idx_c;
            arr_wen_c   = req_wen | ~in_range_c;
            arr_wmask_c = in_range_c ? req_wmask : 4'b0000;
            arr_wdata_c = req_wdata;
        end
    end

    // Control FSM, request latch and latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            wen_q     <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        wen_q     <= req_wen;
                        err_q     <= ~in_range_c;
                        idx_q     <= idx_c;
                        wdata_q   <= req_wdata;
                        wmask_q   <= req_wmask;
                        cnt       <= LAT_LOAD;
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= ~in_range_c;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Word storage; its registered read port drives rsp_rdata directly.
    ysyx_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (commit_c),
        .wen   (arr_wen_c),
        .idx   (arr_idx_c),
        .wdata (arr_wdata_c),
        .wmask (arr_wmask_c),
        .rdata (rsp_rdata)
    );

endmodule

// File: tb/tb_ysyx_mem_responder.sv
// Bench for ysyx_mem_responder: directed vector table, hand-written corner
// sequences and randomized traffic against a word-array reference model.
module tb_ysyx_mem_responder;
    import ysyx_mem_pkg::*;

    localparam logic [31:0] BASE  = DEFAULT_BASE_ADDR;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // index 0: LATENCY=2 instance, index 1: LATENCY=0 instance
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wen   [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    ysyx_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    ysyx_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference model: sparse word store keyed by instance and word number.
    logic [31:0] ref_mem [int];

    task automatic ref_apply(input int s, input logic wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wmask,
                             output logic [31:0] exp_rd, output logic exp_er);
        longint unsigned a, lo, hi;
        int key;
        logic [31:0] w;
        a  = longint'(addr);
        lo = longint'(BASE);
        hi = lo + 64'(4 * DEPTH);
        exp_rd = 32'd0;
        exp_er = 1'b0;
        if (a < lo || a >= hi) begin
            exp_er = 1'b1;
        end else begin
            key = s * int'(DEPTH) + int'((a - lo) / 4);
            w = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
            if (wen) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
                ref_mem[key] = w;
            end else begin
                exp_rd = w;
            end
        end
    endtask

    // One complete request/response; lat counts edges from accept edge to rsp_valid.
    task automatic transact(input int s, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wmask,
                            input int stall,
                            output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = 32'd0; er = 1'b0; lat = 0;
        n = 0;
        while (req_ready[s] !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            timeout_fail("req_ready_wait");
            return;
        end
        rsp_ready[s] = (stall == 0);
        req_valid[s] = 1'b1;
        req_wen[s]   = wen;
        req_addr[s]  = addr;
        req_wdata[s] = wdata;
        req_wmask[s] = wmask;
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        lat = 1;
        while (rsp_valid[s] !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 50) begin
            timeout_fail("rsp_valid_wait");
            rsp_ready[s] = 1'b1;
            return;
        end
        rd = rsp_rdata[s];
        er = rsp_err[s];
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(rsp_valid[s]), 32'd1);
            check("stall_rdata", rsp_rdata[s], rd);
        end
        rsp_ready[s] = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [$];

    int pool [8] = '{0, 1, 2, 3, 511, 1021, 1022, 1023};
    logic [31:0] oob [5] = '{32'h7FFF_FFFC, 32'h8000_1000, 32'h0000_0000,
                             32'hFFFF_FFFC, 32'h8000_1004};

    initial begin
        logic [31:0] rd, exp_rd, a;
        logic er, exp_er, w;
        int lat, c0, c1, r;

        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_wen[s] = 1'b0; req_addr[s] = 32'd0;
            req_wdata[s] = 32'd0; req_wmask[s] = 4'd0; rsp_ready[s] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_req_ready", 32'(req_ready[s]), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
            check("rst_rsp_rdata", rsp_rdata[s], 32'd0);
            check("rst_rsp_err", 32'(rsp_err[s]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(req_ready[0]), 32'd1);

        // Directed vectors on the LATENCY=2 instance.
        vt.push_back('{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, MASK_WORD, 32'h0, 1'b0});
        vt.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0,      32'hDEAD_BEEF, 1'b0});
        vt.push_back('{1'b1, 32'h8000_0020, 32'h1122_3344, MASK_WORD, 32'h0, 1'b0});
        vt.push_back('{1'b1, 32'h8000_0020, 32'h0000_00AA, 4'b0001,   32'h0, 1'b0});
        vt.push_back('{1'b0, 32'h8000_0020, 32'h0,         4'h0,      32'h1122_33AA, 1'b0});
        vt.push_back('{1'b1, 32'h8000_0000, 32'hCAFE_F00D, MASK_WORD, 32'h0, 1'b0});
        vt.push_back('{1'b1, 32'h8000_0FFC, 32'h0BAD_0BAD, MASK_WORD, 32'h0, 1'b0});
        vt.push_back('{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0,      32'h0, 1'b1});
        vt.push_back('{1'b0, 32'h8000_1000, 32'h0,         4'h0,      32'h0, 1'b1});
        vt.push_back('{1'b1, 32'h8000_1000, 32'h5555_5555, MASK_WORD, 32'h0, 1'b1});
        vt.push_back('{1'b1, 32'h7FFF_FFFC, 32'h6666_6666, MASK_WORD, 32'h0, 1'b1});
        vt.push_back('{1'b0, 32'h8000_0000, 32'h0,         4'h0,      32'hCAFE_F00D, 1'b0});
        vt.push_back('{1'b0, 32'h8000_0FFF, 32'h0,         4'h0,      32'h0BAD_0BAD, 1'b0});
        vt.push_back('{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000,   32'h0, 1'b0});
        vt.push_back('{1'b0, 32'h8000_0013, 32'h0,         4'h0,      32'hDEAD_BEEF, 1'b0});
        vt.push_back('{1'b1, 32'h8000_0020, 32'hA5A5_A5A5, 4'b1010,   32'h0, 1'b0});
        vt.push_back('{1'b0, 32'h8000_0020, 32'h0,         4'h0,      32'hA522_A5AA, 1'b0});
        vt.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'h0,      32'hDEAD_BEEF, 1'b0});
        foreach (vt[i]) begin
            transact(0, vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].wmask,
                     (i % 4 == 3) ? 2 : 0, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
        end

        // Backpressure: response frozen for 10 cycles, a request pulse is ignored.
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'h8000_0010;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        r = 0;
        while (rsp_valid[0] !== 1'b1 && r < 50) begin @(posedge clk); #1; r++; end
        if (r >= 50) timeout_fail("bp_valid_wait");
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
            check("bp_err", 32'(rsp_err[0]), 32'd0);
            check("bp_req_ready", 32'(req_ready[0]), 32'd0);
            if (k == 3) begin
                req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = 32'h8000_0010;
                req_wdata[0] = 32'h0; req_wmask[0] = MASK_WORD;
            end else begin
                req_valid[0] = 1'b0;
            end
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(rsp_valid[0]), 32'd0);
        check("bp_release_ready", 32'(req_ready[0]), 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
            check("bp_no_spurious", 32'(rsp_valid[0]), 32'd0);
        end
        transact(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
        check("bp_mem_kept", rd, 32'hDEAD_BEEF);

        // LATENCY=0: back-to-back, one response every 2 cycles.
        transact(1, 1'b1, 32'h8000_0040, 32'h1234_5678, MASK_WORD, 0, rd, er, lat);
        check("l0_warm_lat", 32'(lat), 32'd1);
        c0 = cyc;
        transact(1, 1'b1, 32'h8000_0044, 32'h9ABC_DEF0, MASK_WORD, 0, rd, er, lat);
        check("l0_lat_a", 32'(lat), 32'd1);
        transact(1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 0, rd, er, lat);
        check("l0_lat_b", 32'(lat), 32'd1);
        check("l0_rd_b", rd, 32'h1234_5678);
        transact(1, 1'b0, 32'h8000_0044, 32'h0, 4'h0, 0, rd, er, lat);
        check("l0_rd_c", rd, 32'h9ABC_DEF0);
        transact(1, 1'b0, 32'h8000_1000, 32'h0, 4'h0, 0, rd, er, lat);
        check("l0_err_d", 32'(er), 32'd1);
        c1 = cyc;
        check("l0_throughput", 32'(c1 - c0), 32'd8);

        // Reset during WAIT drops the pending store.
        while (req_ready[0] !== 1'b1) begin @(posedge clk); #1; end
        req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = 32'h8000_0010;
        req_wdata[0] = 32'h1234_5678; req_wmask[0] = MASK_WORD;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("rstw_valid", 32'(rsp_valid[0]), 32'd0);
        check("rstw_ready", 32'(req_ready[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        transact(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
        check("rstw_old_data", rd, 32'hDEAD_BEEF);

        // Reset during RESP drops rsp_valid at once.
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'h8000_0020;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        r = 0;
        while (rsp_valid[0] !== 1'b1 && r < 50) begin @(posedge clk); #1; r++; end
        if (r >= 50) timeout_fail("rstr_valid_wait");
        check("rstr_pre_rdata", rsp_rdata[0], 32'hA522_A5AA);
        rst = 1'b1;
        #1;
        check("rstr_valid", 32'(rsp_valid[0]), 32'd0);
        check("rstr_rdata", rsp_rdata[0], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready[0] = 1'b1;

        // Randomized traffic on both instances against the reference model.
        for (int s = 0; s < 2; s++) begin
            foreach (pool[p]) begin
                a = BASE + 32'(4 * pool[p]);
                ref_apply(s, 1'b1, a, $urandom, MASK_WORD, exp_rd, exp_er);
                transact(s, 1'b1, a, ref_mem[s * int'(DEPTH) + pool[p]], MASK_WORD,
                         0, rd, er, lat);
                check("pre_err", 32'(er), 32'(exp_er));
            end
            for (int t = 0; t < 80; t++) begin
                r = int'($urandom_range(0, 9));
                if (r < 8) a = BASE + 32'(4 * pool[r]) + 32'($urandom_range(0, 3));
                else       a = oob[$urandom_range(0, 4)];
                w = 1'($urandom_range(0, 1));
                begin
                    logic [31:0] wd;
                    logic [3:0] wm;
                    wd = $urandom;
                    wm = 4'($urandom_range(0, 15));
                    ref_apply(s, w, a, wd, wm, exp_rd, exp_er);
                    transact(s, w, a, wd, wm, int'($urandom_range(0, 2)), rd, er, lat);
                end
                check($sformatf("rnd%0d_%0d_rdata", s, t), rd, exp_rd);
                check($sformatf("rnd%0d_%0d_err", s, t), 32'(er), 32'(exp_er));
                check($sformatf("rnd%0d_%0d_lat", s, t), 32'(lat), (s == 0) ? 32'd3 : 32'd1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
